logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 2, result buffer entries (power of two, range 2..16).
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port A, input, WIDTH bits, first operand.
REQ-006 SHALL have port B, input, WIDTH bits, second operand.
REQ-007 SHALL have port OP, input, 3 bits, operation select.
REQ-008 SHALL have port IN_VALID, input, 1 bit, meaning A/B/OP are valid.
REQ-009 SHALL have port IN_READY, output, 1 bit, meaning the block can accept an operation.
REQ-010 SHALL have port C, output, WIDTH bits, result at the buffer head.
REQ-011 SHALL have port ZERO, output, 1 bit, high when the head result is all zeros.
REQ-012 SHALL have port OUT_VALID, output, 1 bit, meaning C/ZERO are valid.
REQ-013 SHALL have port OUT_READY, input, 1 bit, meaning the consumer accepts the result.

Function
REQ-014 SHALL compute per bit: OP 000 NOR, 001 OR, 010 AND, 011 NAND, 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 pass A.
REQ-015 SHALL accept an operation in a cycle with IN_VALID=1 and IN_READY=1, and SHALL write its result and ZERO flag into the buffer tail at that edge.
REQ-016 SHALL present an accepted result on C with OUT_VALID=1 exactly one cycle after acceptance when the buffer was empty.
REQ-017 SHALL complete a pop in a cycle with OUT_VALID=1 and OUT_READY=1; the next entry SHALL appear on C in the following cycle.
REQ-018 SHALL deliver results strictly in acceptance order, with no loss and no duplication.
REQ-019 SHALL drive IN_READY = (count < DEPTH), registered-state-derived only, with no combinational path from OUT_READY.
REQ-020 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and advance both pointers.
REQ-021 SHALL hold IN_READY=0 while full (count=DEPTH); IN_VALID in that state SHALL be ignored, even with OUT_READY=1.
REQ-022 SHALL hold C, ZERO and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH, and SHALL track count in clog2(DEPTH)+1 bits.
REQ-024 SHALL drive C to all zeros and ZERO=0 whenever OUT_VALID=0.
REQ-025 SHALL treat OUT_READY=1 while empty as a no-op.

Reset
REQ-026 SHALL, while RST_N=0, immediately force: count=0, pointers=0, OUT_VALID=0, C=0, ZERO=0, IN_READY=0.
REQ-027 SHALL discard all buffered results on reset mid-operation; nothing issued before reset SHALL appear afterward.
REQ-028 SHALL assert IN_READY=1 on the first rising CLK edge after RST_N deasserts.
REQ-029 SHALL leave buffer storage contents unreset, since it is unobservable.

Configuration
REQ-030 SHALL, with LOGIC_UNIT_POPCNT_EN defined, add output POP, clog2(WIDTH+1) bits, holding the popcount of C, buffered alongside C with the same latency and stall rules, and 0 when OUT_VALID=0.
REQ-031 SHALL, without LOGIC_UNIT_POPCNT_EN, have no POP port and no popcount logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: reset, then A=32'hFFFF0000, B=32'h00FF00FF, OP=000 accepted -> next cycle OUT_VALID=1, C=32'h0000FF00, ZERO=0 (POP=8 if enabled).
REQ-033 SHALL cover: OP=110, A=32'hFFFFFFFF -> C=32'h00000000, ZERO=1 (POP=0).
REQ-034 SHALL cover: OUT_READY=0 and 3 pushes with DEPTH=2 -> IN_READY drops after the 2nd accept, the 3rd is held; raising OUT_READY delivers all 3 in order.
REQ-035 SHALL cover: buffer holding 1 entry with push and pop in the same cycle -> count stays 1, the new result follows, OUT_VALID never drops.
REQ-036 SHALL cover: RST_N pulsed low with 2 entries buffered -> OUT_VALID=0 and IN_READY=0 at once, and no stale result after release.
REQ-037 SHALL cover: random OP/A/B with random OUT_READY stalls, 10k operations, WIDTH=8 and WIDTH=64 -> all outputs match the reference model in order.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a DEPTH-entry result FIFO with valid/ready on both sides.
// Define LOGIC_UNIT_POPCNT_EN to add the POP output (popcount of C, buffered with C).
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] C,
    output logic             ZERO,
`ifdef LOGIC_UNIT_POPCNT_EN
    output logic [$clog2(WIDTH+1)-1:0] POP,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int POP_W = $clog2(WIDTH + 1);
`endif

    typedef enum logic [2:0] {
        OP_NOR  = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_NAND = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
`ifdef LOGIC_UNIT_POPCNT_EN
        logic [POP_W-1:0] pop;
`endif
    } entry_t;

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] op_table(input op_e op);
        logic [3:0] tt;
        unique case (op)
            OP_NOR:  tt = 4'b0001;
            OP_OR:   tt = 4'b1110;
            OP_AND:  tt = 4'b1000;
            OP_NAND: tt = 4'b0111;
            OP_XOR:  tt = 4'b0110;
            OP_XNOR: tt = 4'b1001;
            OP_NOTA: tt = 4'b0011;
            OP_PASS: tt = 4'b1100;
        endcase
        return tt;
    endfunction

`ifdef LOGIC_UNIT_POPCNT_EN
    function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             armed;
    logic [3:0]       tt;
    logic [WIDTH-1:0] result;
    entry_t           new_entry;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // armed keeps IN_READY low until the first edge after reset release.
    assign IN_READY  = armed && (count < CNT_W'(DEPTH));
    assign OUT_VALID = (count != '0);
    assign do_push   = IN_VALID && IN_READY;
    assign do_pop    = OUT_VALID && OUT_READY;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tt     = op_table(op_e'(OP));
        result = '0;
        for (int i = 0; i < WIDTH; i++) result[i] = tt[{A[i], B[i]}];
    end

    always_comb begin
        new_entry      = '0;
        new_entry.data = result;
        new_entry.zero = ~|result;
`ifdef LOGIC_UNIT_POPCNT_EN
        new_entry.pop  = popcount(result);
`endif
    end

    // NOTE: storage has no reset; only entries below count are ever presented.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= new_entry;
    end

    // NOTE: state updates use <= so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign C    = OUT_VALID ? head.data : '0;
    assign ZERO = OUT_VALID && head.zero;
`ifdef LOGIC_UNIT_POPCNT_EN
    assign POP  = OUT_VALID ? head.pop : '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: WIDTH 8/32/64 instances in lockstep against a queue model.
// Honours LOGIC_UNIT_POPCNT_EN to also check POP.
module tb_logic_unit_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a, b;
    logic [2:0]  op;
    logic        in_valid, out_ready;

    logic        rdy8, rdy32, rdy64;
    logic        ov8, ov32, ov64;
    logic        z8, z32, z64;
    logic [7:0]  c8;
    logic [31:0] c32;
    logic [63:0] c64;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [3:0]  pop8;
    logic [5:0]  pop32;
    logic [6:0]  pop64;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mq[$];
    bit          armed;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(DEPTH)) dut8 (
        .CLK(clk), .RST_N(rst_n), .A(a[7:0]), .B(b[7:0]), .OP(op),
        .IN_VALID(in_valid), .IN_READY(rdy8), .C(c8), .ZERO(z8),
`ifdef LOGIC_UNIT_POPCNT_EN
        .POP(pop8),
`endif
        .OUT_VALID(ov8), .OUT_READY(out_ready)
    );

    logic_unit_pipe #(.WIDTH(32), .DEPTH(DEPTH)) dut32 (
        .CLK(clk), .RST_N(rst_n), .A(a[31:0]), .B(b[31:0]), .OP(op),
        .IN_VALID(in_valid), .IN_READY(rdy32), .C(c32), .ZERO(z32),
`ifdef LOGIC_UNIT_POPCNT_EN
        .POP(pop32),
`endif
        .OUT_VALID(ov32), .OUT_READY(out_ready)
    );

    logic_unit_pipe #(.WIDTH(64), .DEPTH(DEPTH)) dut64 (
        .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .OP(op),
        .IN_VALID(in_valid), .IN_READY(rdy64), .C(c64), .ZERO(z64),
`ifdef LOGIC_UNIT_POPCNT_EN
        .POP(pop64),
`endif
        .OUT_VALID(ov64), .OUT_READY(out_ready)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_zero;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        case (o)
            3'd0: return ~(x | y);
            3'd1: return x | y;
            3'd2: return x & y;
            3'd3: return ~(x & y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    function automatic bit exp_ready();
        return armed && (mq.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        bit          ev;
        logic [63:0] h;
        ev = (mq.size() > 0);
        h  = ev ? mq[0] : 64'h0;
        check("in_ready8",  rdy8,  exp_ready());
        check("in_ready32", rdy32, exp_ready());
        check("in_ready64", rdy64, exp_ready());
        check("out_valid8",  ov8,  ev);
        check("out_valid32", ov32, ev);
        check("out_valid64", ov64, ev);
        check("c8",  c8,  {56'h0, h[7:0]});
        check("c32", c32, {32'h0, h[31:0]});
        check("c64", c64, h);
        check("zero8",  z8,  ev && (h[7:0] == 8'h0));
        check("zero32", z32, ev && (h[31:0] == 32'h0));
        check("zero64", z64, ev && (h == 64'h0));
`ifdef LOGIC_UNIT_POPCNT_EN
        check("pop8",  pop8,  $countones(h[7:0]));
        check("pop32", pop32, $countones(h[31:0]));
        check("pop64", pop64, $countones(h));
`endif
    endtask

    // Check outputs, take one clock edge, then advance the model; returns at posedge+1.
    task automatic cycle();
        bit acc, pp;
        logic [63:0] r;
        check_outputs();
        acc = in_valid && exp_ready();
        pp  = out_ready && (mq.size() > 0);
        r   = ref_op(op, a, b);
        @(posedge clk);
        #1;
        if (pp)    void'(mq.pop_front());
        if (acc)   mq.push_back(r);
        if (rst_n) armed = 1'b1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        op = o;
        a  = x;
        b  = y;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] e0, e1, e2;
        int accepted, cyc;

        tv.push_back('{3'b000, 32'hFFFF0000, 32'h00FF00FF, 32'h0000FF00, 1'b0});
        tv.push_back('{3'b001, 32'hFFFF0000, 32'h00FF00FF, 32'hFFFF00FF, 1'b0});
        tv.push_back('{3'b010, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000, 1'b0});
        tv.push_back('{3'b011, 32'hFFFF0000, 32'h00FF00FF, 32'hFF00FFFF, 1'b0});
        tv.push_back('{3'b100, 32'hFFFF0000, 32'h00FF00FF, 32'hFF0000FF, 1'b0});
        tv.push_back('{3'b101, 32'hFFFF0000, 32'h00FF00FF, 32'h00FFFF00, 1'b0});
        tv.push_back('{3'b110, 32'hFFFF0000, 32'h00FF00FF, 32'h0000FFFF, 1'b0});
        tv.push_back('{3'b111, 32'hFFFF0000, 32'h00FF00FF, 32'hFFFF0000, 1'b0});
        tv.push_back('{3'b110, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1'b1});
        tv.push_back('{3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1});
        tv.push_back('{3'b100, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1});
        tv.push_back('{3'b111, 32'h80000001, 32'hFFFFFFFF, 32'h80000001, 1'b0});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 64'h0, 64'h0);
        armed = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("ready_first_edge", rdy32, 1'b1);

        // Table: each op into an empty buffer, visible exactly one cycle later.
        foreach (tv[i]) begin
            drive(tv[i].op, {$urandom, tv[i].a}, {$urandom, tv[i].b});
            in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), ov32, 1'b1);
            check($sformatf("vec%0d_c", i), c32, tv[i].exp_c);
            check($sformatf("vec%0d_zero", i), z32, tv[i].exp_zero);
`ifdef LOGIC_UNIT_POPCNT_EN
            check($sformatf("vec%0d_pop", i), pop32, $countones(tv[i].exp_c));
`endif
            cycle();
        end

        // Fill to full with the consumer stalled; the third op is held off.
        e0 = 64'h0123456789ABCDEF; e1 = 64'hFEDCBA9876543210; e2 = 64'h00FF00FF00FF00FF;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3'd4, e0, 64'h0); cycle();
        drive(3'd1, e1, 64'h0); cycle();
        check("full_in_ready", rdy32, 1'b0);
        drive(3'd7, e2, 64'h0); cycle();
        check("stall_head", c32, e0[31:0]);
        out_ready = 1'b1;
        cycle();
        check("order_second", c32, e1[31:0]);
        cycle();
        check("order_third", c32, e2[31:0]);
        in_valid = 1'b0;
        cycle();
        check("order_drained", ov32, 1'b0);

        // One entry buffered, simultaneous push and pop.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3'd7, 64'hAAAA5555AAAA5555, 64'h0); cycle();
        drive(3'd6, 64'h0F0F0F0F0F0F0F0F, 64'h0);
        out_ready = 1'b1;
        cycle();
        check("pushpop_valid", ov32, 1'b1);
        check("pushpop_c", c32, 32'hF0F0F0F0);
        check("pushpop_ready", rdy32, 1'b1);
        in_valid = 1'b0;
        cycle();

        // Reset with two entries buffered.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3'd7, 64'h1111111111111111, 64'h0); cycle();
        drive(3'd7, 64'h2222222222222222, 64'h0); cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", ov32, 1'b0);
        check("rst_in_ready", rdy32, 1'b0);
        check("rst_c", c32, 32'h0);
        check("rst_zero", z32, 1'b0);
        mq.delete();
        armed = 1'b0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        check("rst_release_ready", rdy32, 1'b1);
        for (int i = 0; i < 3; i++) cycle();

        // Random ops with random consumer stalls.
        accepted = 0; cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            if (in_valid && exp_ready()) accepted++;
            cycle();
            cyc++;
        end
        check("random_ops_done", accepted, 10000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) cycle();
        check("final_empty", ov32, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
